// File: rtl/bip_pkg.sv
// Shared types and constants for the BIP core.
// Opcodes, widths and the decoded control word.
package bip_pkg;

  localparam int PC_W   = 11;
  localparam int OPR_W  = 11;
  localparam int DATA_W = 16;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef struct packed {
    logic       wr_pc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op_sub;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] sext(
    input logic [OPR_W-1:0] v
  );
    return {{(DATA_W-OPR_W){v[OPR_W-1]}}, v};
  endfunction

endpackage

// File: rtl/bip_control.sv
// BIP control unit: opcode decode and program counter.
// PC freezes on HLT and wraps naturally at the top of memory.
module bip_control
  import bip_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      opcode,
  output ctrl_t           ctrl,
  output logic [PC_W-1:0] pc
);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_HLT): ctrl = '0;
      (opcode == OP_STO): begin
        ctrl.wr_pc  = 1'b1;
        ctrl.wr_ram = 1'b1;
      end
      (opcode == OP_LD): begin
        ctrl.wr_pc  = 1'b1;
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_MEM;
      end
      (opcode == OP_LDI): begin
        ctrl.wr_pc  = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_IMM;
      end
      (opcode == OP_ADD): begin
        ctrl.wr_pc  = 1'b1;
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
      end
      (opcode == OP_ADDI): begin
        ctrl.wr_pc  = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = 1'b1;
      end
      (opcode == OP_SUB): begin
        ctrl.wr_pc  = 1'b1;
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.op_sub = 1'b1;
      end
      (opcode == OP_SUBI): begin
        ctrl.wr_pc  = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.op_sub = 1'b1;
      end
      default: ctrl.wr_pc = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= '0;
    else if (ctrl.wr_pc)
      pc <= pc + 11'd1;
  end

endmodule

// File: rtl/main.sv
// BIP top: control unit plus accumulator datapath.
// One instruction per clock against external async memories.
module main
  import bip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] Addr,
  input  logic [15:0] Data,
  output logic        WrRam,
  output logic        RdRam,
  output logic [10:0] Addr_DM,
  output logic [15:0] In_Data,
  input  logic [15:0] Out_Data
);

  ctrl_t             ctrl;
  logic [PC_W-1:0]   pc;
  logic [OPR_W-1:0]  operand;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] acc_d;

  assign operand = Data[15:5];

  bip_control u_control (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (Data[4:0]),
    .ctrl   (ctrl),
    .pc     (pc)
  );

  assign imm   = sext(operand);
  assign alu_b = ctrl.sel_b ? imm : Out_Data;
  assign alu_y = ctrl.op_sub ? acc - alu_b
                             : acc + alu_b;

  always_comb begin
    acc_d = alu_y;
    unique case (ctrl.sel_a)
      SEL_A_MEM: acc_d = Out_Data;
      SEL_A_IMM: acc_d = imm;
      default:   acc_d = alu_y;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (ctrl.wr_acc)
      acc <= acc_d;
  end

  assign Addr    = pc;
  assign WrRam   = ctrl.wr_ram;
  assign RdRam   = ctrl.rd_ram;
  assign Addr_DM = operand;
  assign In_Data = acc;

endmodule

// File: tb/tb_main.sv
// Directed self-checking bench for the BIP top.
// Inputs change on falling edges; outputs sampled 1ns later.
module tb_main;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] Addr;
  logic [15:0] Data;
  logic        WrRam;
  logic        RdRam;
  logic [10:0] Addr_DM;
  logic [15:0] In_Data;
  logic [15:0] Out_Data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  main dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Addr     (Addr),
    .Data     (Data),
    .WrRam    (WrRam),
    .RdRam    (RdRam),
    .Addr_DM  (Addr_DM),
    .In_Data  (In_Data),
    .Out_Data (Out_Data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Data = 16'h1FA0;
    Out_Data = 16'h0000;
    #3;
    total++;
    if (Addr !== 11'h000 || In_Data !== 16'h0000)
      $display("FAIL reset_state Addr=%h In_Data=%h want 000/0000",
               Addr, In_Data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    total++;
    if (Addr !== 11'h000)
      $display("FAIL hlt_hold Addr=%h want 000", Addr);
    else passed++;
    total++;
    if (WrRam !== 1'b0 || RdRam !== 1'b0 || In_Data !== 16'h0000)
      $display("FAIL hlt_ctrl Wr=%b Rd=%b In=%h want 0/0/0000",
               WrRam, RdRam, In_Data);
    else passed++;
  endtask

  task automatic test_sto();
    @(negedge clk);
    Data = 16'h1FA1;
    #1;
    total++;
    if (WrRam !== 1'b1 || RdRam !== 1'b0)
      $display("FAIL sto_ctrl Wr=%b Rd=%b want 1/0", WrRam, RdRam);
    else passed++;
    total++;
    if (Addr_DM !== 11'h0FD || In_Data !== 16'h0000)
      $display("FAIL sto_data Addr_DM=%h In=%h want 0fd/0000",
               Addr_DM, In_Data);
    else passed++;
    step();
    total++;
    if (Addr !== 11'h001)
      $display("FAIL sto_pc Addr=%h want 001", Addr);
    else passed++;
  endtask

  task automatic test_load();
    @(negedge clk);
    Data = 16'h1FA2;
    Out_Data = 16'h0001;
    #1;
    total++;
    if (RdRam !== 1'b1 || WrRam !== 1'b0)
      $display("FAIL ld_ctrl Rd=%b Wr=%b want 1/0", RdRam, WrRam);
    else passed++;
    step();
    total++;
    if (In_Data !== 16'h0001 || Addr !== 11'h002)
      $display("FAIL ld_acc In=%h Addr=%h want 0001/002",
               In_Data, Addr);
    else passed++;
    @(negedge clk);
    Data = 16'h1FA3;
    #1;
    total++;
    if (RdRam !== 1'b0)
      $display("FAIL ldi_rd Rd=%b want 0", RdRam);
    else passed++;
    step();
    total++;
    if (In_Data !== 16'h00FD)
      $display("FAIL ldi_acc In=%h want 00fd", In_Data);
    else passed++;
  endtask

  task automatic test_arith();
    logic [15:0] ops [4];
    logic [15:0] exp [4];
    ops = '{16'h1FA4, 16'h1FA5, 16'h1FA6, 16'h1FA7};
    exp = '{16'h03FE, 16'h04FB, 16'h01FA, 16'h00FD};
    Out_Data = 16'h0301;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Data = ops[i];
      step();
      total++;
      if (In_Data !== exp[i])
        $display("FAIL arith_%0d In=%h want %h", i, In_Data, exp[i]);
      else passed++;
    end
    total++;
    if (Addr !== 11'h007)
      $display("FAIL arith_pc Addr=%h want 007", Addr);
    else passed++;
  endtask

  task automatic test_sign_wrap();
    @(negedge clk);
    Data = 16'hFFE3;
    step();
    total++;
    if (In_Data !== 16'hFFFF)
      $display("FAIL ldi_neg In=%h want ffff", In_Data);
    else passed++;
    @(negedge clk);
    Data = 16'h0025;
    step();
    total++;
    if (In_Data !== 16'h0000)
      $display("FAIL addi_wrap In=%h want 0000", In_Data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    Data = 16'h00A5;
    step();
    @(negedge clk);
    Data = 16'h0001;
    #1;
    total++;
    if (In_Data !== 16'h0005 || WrRam !== 1'b1 || Addr_DM !== 11'h000)
      $display("FAIL sto_after_addi In=%h Wr=%b DM=%h want 0005/1/000",
               In_Data, WrRam, Addr_DM);
    else passed++;
    step();
    total++;
    if (Addr !== 11'h00B)
      $display("FAIL b2b_pc Addr=%h want 00b", Addr);
    else passed++;
  endtask

  task automatic test_pc_wrap();
    @(negedge clk);
    Data = 16'h0008;
    repeat (11'h7FF - 11'h00B) step();
    total++;
    if (Addr !== 11'h7FF)
      $display("FAIL pc_top Addr=%h want 7ff", Addr);
    else passed++;
    step();
    total++;
    if (Addr !== 11'h000)
      $display("FAIL pc_wrap Addr=%h want 000", Addr);
    else passed++;
    repeat (11) step();
    total++;
    if (Addr !== 11'h00B || In_Data !== 16'h0005)
      $display("FAIL nop_hold Addr=%h In=%h want 00b/0005",
               Addr, In_Data);
    else passed++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (Addr !== 11'h000 || In_Data !== 16'h0000)
      $display("FAIL async_rst Addr=%h In=%h want 000/0000",
               Addr, In_Data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    Data = 16'h0063;
    step();
    total++;
    if (Addr !== 11'h001 || In_Data !== 16'h0003)
      $display("FAIL post_rst Addr=%h In=%h want 001/0003",
               Addr, In_Data);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sto();
    test_load();
    test_arith();
    test_sign_wrap();
    test_back_to_back();
    test_pc_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
